// File: rtl/biu_constants_pkg.sv
// Shared types and constants for the BIU memory-port arbiter.
package biu_constants_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } biu_size_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_t;

   localparam logic ARB_OWNER_IF = 1'b0;
   localparam logic ARB_OWNER_DM = 1'b1;

   // Wide enough for the largest TIMEOUT value (255)
   localparam int ARB_TMO_W = 8;

endpackage

// File: rtl/biu_arb_timeout.sv
// Grant watchdog: counts BUSY cycles since the last grant, flags the final allowed cycle.
module biu_arb_timeout
   import biu_constants_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [ARB_TMO_W-1:0] LIMIT = ARB_TMO_W'(TIMEOUT - 1);

   logic [ARB_TMO_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt holds (BUSY cycle index - 1), so this fires during BUSY cycle number TIMEOUT
   assign expired = en && (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/biu_mem_arbiter.sv
// Two-master (fetch / data) arbiter onto one memory port, one transaction outstanding.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate grants on simultaneous requests).
module biu_mem_arbiter
   import biu_constants_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_adr,
   output logic            if_ack,
   output logic            if_err,
   output logic [XLEN-1:0] if_q,
   input  logic            dm_req,
   input  logic [XLEN-1:0] dm_adr,
   input  logic [XLEN-1:0] dm_d,
   input  logic            dm_we,
   input  biu_size_t       dm_size,
   output logic            dm_ack,
   output logic            dm_err,
   output logic [XLEN-1:0] dm_q,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_adr,
   output logic [XLEN-1:0] mem_d,
   output logic            mem_we,
   output biu_size_t       mem_size,
   input  logic [XLEN-1:0] mem_q,
   input  logic            mem_ack,
   input  logic            mem_err,
   output logic            arb_owner,
   output logic            arb_busy
);

   arb_state_t      r_state, w_state_nxt;
   logic            r_if_ack, r_if_err, r_dm_ack, r_dm_err;
   logic [XLEN-1:0] r_if_q, r_dm_q;
   logic [XLEN-1:0] r_adr, r_d;
   logic            r_we;
   biu_size_t       r_size;

   logic w_if_elig, w_dm_elig, w_pick_dm;
   logic w_grant_if, w_grant_dm;
   logic w_rsp_ack, w_rsp_err;
   logic w_expired;

   // A requester being answered this cycle cannot be re-granted in the same cycle
   assign w_if_elig = if_req & ~r_if_ack & ~r_if_err;
   assign w_dm_elig = dm_req & ~r_dm_ack & ~r_dm_err;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last;

   assign w_pick_dm = (r_last == ARB_OWNER_IF);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last <= ARB_OWNER_IF;
      end else if (w_grant_if) begin
         r_last <= ARB_OWNER_IF;
      end else if (w_grant_dm) begin
         r_last <= ARB_OWNER_DM;
      end
   end
`else
   assign w_pick_dm = 1'b1;
`endif

   biu_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (w_grant_if | w_grant_dm),
      .en      (r_state != IDLE),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Response priority: err > ack > timeout; mem_ack/mem_err are ignored in IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_grant_if  = 1'b0;
      w_grant_dm  = 1'b0;
      w_rsp_ack   = 1'b0;
      w_rsp_err   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dm_elig && (!w_if_elig || w_pick_dm)) begin
               w_grant_dm  = 1'b1;
               w_state_nxt = BUSY_DM;
            end else if (w_if_elig) begin
               w_grant_if  = 1'b1;
               w_state_nxt = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (mem_err) begin
               w_rsp_err = 1'b1;
            end else if (mem_ack) begin
               w_rsp_ack = 1'b1;
            end else if (w_expired) begin
               w_rsp_err = 1'b1;
            end
            if (w_rsp_ack || w_rsp_err) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_if_ack <= 1'b0;
         r_if_err <= 1'b0;
         r_dm_ack <= 1'b0;
         r_dm_err <= 1'b0;
         r_if_q   <= '0;
         r_dm_q   <= '0;
         r_adr    <= '0;
         r_d      <= '0;
         r_we     <= 1'b0;
         r_size   <= BYTE;
      end else begin
         r_if_ack <= w_rsp_ack & (r_state == BUSY_IF);
         r_if_err <= w_rsp_err & (r_state == BUSY_IF);
         r_dm_ack <= w_rsp_ack & (r_state == BUSY_DM);
         r_dm_err <= w_rsp_err & (r_state == BUSY_DM);
         if (w_rsp_ack && (r_state == BUSY_IF)) begin
            r_if_q <= mem_q;
         end
         if (w_rsp_ack && (r_state == BUSY_DM)) begin
            r_dm_q <= mem_q;
         end
         if (w_grant_if) begin
            r_adr  <= if_adr;
            r_d    <= '0;
            r_we   <= 1'b0;
            r_size <= WORD;
         end else if (w_grant_dm) begin
            r_adr  <= dm_adr;
            r_d    <= dm_d;
            r_we   <= dm_we;
            r_size <= dm_size;
         end
      end
   end

   assign if_ack    = r_if_ack;
   assign if_err    = r_if_err;
   assign if_q      = r_if_q;
   assign dm_ack    = r_dm_ack;
   assign dm_err    = r_dm_err;
   assign dm_q      = r_dm_q;
   assign mem_req   = (r_state != IDLE);
   assign mem_adr   = r_adr;
   assign mem_d     = r_d;
   assign mem_we    = r_we;
   assign mem_size  = r_size;
   assign arb_owner = (r_state == BUSY_DM) ? ARB_OWNER_DM : ARB_OWNER_IF;
   assign arb_busy  = (r_state != IDLE);

endmodule

// File: doc/biu_mem_arbiter.md
BIU_MEM_ARBITER -- requirements
Module: biu_mem_arbiter

Interface
REQ-001 Parameter XLEN, 32, address and data width.
REQ-002 Parameter TIMEOUT, 255, maximum cycles a grant waits for ack or err; 0 disables the timeout; range 0..255.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rstn  in  1  reset; asynchronous, active-low.
REQ-005 if_req  in  1  instruction-fetch request; level, held until if_ack or if_err.
REQ-006 if_adr  in  XLEN  instruction-fetch address.
REQ-007 if_ack, if_err  out  1 each  instruction completion and error pulses.
REQ-008 if_q  out  XLEN  instruction read data; valid with if_ack.
REQ-009 dm_req  in  1  data request; level, held until dm_ack or dm_err.
REQ-010 dm_adr, dm_d  in  XLEN each  data address and write data.
REQ-011 dm_we  in  1  data write enable.
REQ-012 dm_size  in  biu_size_t  data access size.
REQ-013 dm_ack, dm_err  out  1 each  data completion and error pulses.
REQ-014 dm_q  out  XLEN  data read data; valid with dm_ack.
REQ-015 mem_req  out  1  shared memory-port request.
REQ-016 mem_adr, mem_d  out  XLEN each  shared port address and write data.
REQ-017 mem_we  out  1  shared port write enable.
REQ-018 mem_size  out  biu_size_t  shared port access size.
REQ-019 mem_q  in  XLEN  shared port read data.
REQ-020 mem_ack, mem_err  in  1 each  shared port completion and error.
REQ-021 arb_owner  out  1  current owner: 0 = fetch, 1 = data.
REQ-022 arb_busy  out  1  a transaction is outstanding.

Function
REQ-023 The FSM has three states: IDLE, BUSY_IF, BUSY_DM. At most one transaction is outstanding.
REQ-024 IDLE with exactly one eligible request -> BUSY of that requester on the next edge. Its address, data, we and size are latched at that edge.
REQ-025 Both eligible in IDLE: the arbitration policy in REQ-036/037 decides the grant.
REQ-026 mem_req = (state != IDLE). mem_* outputs come from the latched registers. Grant latency is 1 cycle from request to mem_req.
REQ-027 A fetch grant drives mem_we=0 and mem_size=WORD (biu_constants_pkg).
REQ-028 In BUSY, mem_ack -> registered requester ack pulse on the next cycle, with q = mem_q captured at the ack edge; state returns to IDLE.
REQ-029 In BUSY, mem_err -> registered requester err pulse on the next cycle; state returns to IDLE. If mem_ack and mem_err arrive together, err wins.
REQ-030 The timeout counter clears at grant and increments each BUSY cycle. When it reaches TIMEOUT without ack or err, the arbiter issues a requester err pulse and returns to IDLE. If ack and timeout occur in the same cycle, ack wins.
REQ-031 mem_ack and mem_err are ignored in IDLE, so late responses after a timeout are dropped.
REQ-032 A requester whose ack or err is high in the current cycle is not eligible for a grant in that cycle.
REQ-033 A requester that drops req mid-transaction is a protocol violation. The arbiter completes the transaction and still pulses ack or err.
REQ-034 The ack and err outputs of the non-owner are always 0. q outputs hold their last value.

Reset
REQ-035 Asserting rstn at any time forces state=IDLE, mem_req=0, all ack and err outputs=0, q outputs=0, latched registers=0, counter=0, arb_owner=0, arb_busy=0, last-served=fetch. Any in-flight transaction is abandoned without a response.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined, simultaneous requests are granted to the requester that was not last served. Last-served updates at each grant.
REQ-037 Without ARB_ROUND_ROBIN_EN, simultaneous requests always grant data. The last-served register is not built.

Structure
REQ-038 arb_state_t (IDLE, BUSY_IF, BUSY_DM) and the owner constants ARB_OWNER_IF=0 and ARB_OWNER_DM=1 live in biu_constants_pkg.
REQ-039 The timeout counter is the sub-module biu_arb_timeout, with ports clk, rstn, clr, en, and expired.

Verification
REQ-040 Fetch only, if_adr=0x200, mem_ack on the 3rd BUSY cycle with mem_q=0x00000013 -> mem_req high for 3 cycles; if_ack 1 cycle with if_q=0x13.
REQ-041 Simultaneous requests from reset, round-robin enabled -> data granted first, then fetch; without the macro, data both times while dm_req stays held.
REQ-042 Data write dm_adr=0x1000, dm_d=0xDEADBEEF, size WORD, mem_ack and mem_err together -> dm_err pulse, no dm_ack.
REQ-043 TIMEOUT=4, no response -> dm_err 1 cycle after the 4th BUSY cycle; a mem_ack 2 cycles later is ignored.
REQ-044 rstn low during BUSY_IF -> mem_req=0 immediately; no if_ack or if_err ever issued for that fetch.
REQ-045 Back-to-back: the fetch holds if_req through if_ack while data is pending -> data granted in the if_ack cycle; fetch is not re-granted in that cycle.
